// File: rtl/aes_enc_pkg.sv
// Shared types, Rcon table and GF(2^8) round-transform helpers for aes_encrypt.
// Bytes follow FIPS-197 order: byte 0 is bits [127:120], and the state is filled column-major.
package aes_enc_pkg;

    localparam int unsigned NR = 10;

    typedef enum logic [1:0] {WAIT, ROUND, DONE} aes_state_t;
    typedef enum logic {SUB_SHIFT, MIX_ADD} round_phase_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] cur;
        acc = '0;
        cur = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ cur;
            cur = xtime(cur);
        end
        return acc;
    endfunction

    // Byte r of column c is state byte r + 4*c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03);
            r[103 - 32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: one 8-bit table lookup.
module aes_sbox
    import aes_enc_pkg::*;
(
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_val = SBOX_TABLE[byte_val];

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor with an on-the-fly key schedule; one round per cycle by default.
// Defining AES_ENC_SPLIT_ROUND_EN splits each round into SUB_SHIFT and MIX_ADD cycles.
module aes_encrypt #(
    parameter int unsigned NR = aes_enc_pkg::NR
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_DEC,
    output logic [127:0] AES_MSG_ENC,
    output logic         AES_DONE
);
    import aes_enc_pkg::*;

    aes_state_t   fsm;
    logic [127:0] state;
    logic [127:0] rkey;
    logic [3:0]   round;
`ifdef AES_ENC_SPLIT_ROUND_EN
    round_phase_t phase;
    logic [127:0] shifted;
`endif

    logic [127:0] sub_bytes;
    logic [31:0]  rot_word;
    logic [31:0]  key_sub;
    logic [127:0] next_rk;
    logic [127:0] round_out;
    logic         last_round;

    for (genvar b = 0; b < 16; b++) begin : g_state_sbox
        aes_sbox u_sbox (
            .byte_val (state[127 - 8*b -: 8]),
            .sub_val  (sub_bytes[127 - 8*b -: 8])
        );
    end

    assign rot_word = {rkey[23:0], rkey[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_key_sbox
        aes_sbox u_sbox (
            .byte_val (rot_word[31 - 8*k -: 8]),
            .sub_val  (key_sub[31 - 8*k -: 8])
        );
    end

    assign last_round = (round == 4'(NR));

    always_comb begin
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        t  = key_sub ^ {rcon(round), 24'h000000};
        w0 = rkey[127:96] ^ t;
        w1 = rkey[95:64]  ^ w0;
        w2 = rkey[63:32]  ^ w1;
        w3 = rkey[31:0]   ^ w2;
        next_rk = {w0, w1, w2, w3};
    end

`ifdef AES_ENC_SPLIT_ROUND_EN
    // The S-box bank output is registered as ShiftRows(SubBytes) in the first half-round.
    always_comb begin
        shifted   = shift_rows(sub_bytes);
        round_out = (last_round ? state : mix_columns(state)) ^ next_rk;
    end
`else
    always_comb begin
        logic [127:0] sr;
        sr        = shift_rows(sub_bytes);
        round_out = (last_round ? sr : mix_columns(sr)) ^ next_rk;
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fsm         <= WAIT;
            state       <= '0;
            rkey        <= '0;
            round       <= '0;
            AES_MSG_ENC <= '0;
            AES_DONE    <= 1'b0;
`ifdef AES_ENC_SPLIT_ROUND_EN
            phase       <= SUB_SHIFT;
`endif
        end else begin
            case (fsm)
                WAIT: begin
                    if (AES_START) begin
                        state <= AES_MSG_DEC ^ AES_KEY;
                        rkey  <= AES_KEY;
                        round <= 4'd1;
                        fsm   <= ROUND;
`ifdef AES_ENC_SPLIT_ROUND_EN
                        phase <= SUB_SHIFT;
`endif
                    end
                end
                ROUND: begin
`ifdef AES_ENC_SPLIT_ROUND_EN
                    if (phase == SUB_SHIFT) begin
                        state <= shifted;
                        phase <= MIX_ADD;
                    end else begin
                        state <= round_out;
                        rkey  <= next_rk;
                        phase <= SUB_SHIFT;
                        if (last_round) begin
                            AES_MSG_ENC <= round_out;
                            AES_DONE    <= 1'b1;
                            fsm         <= DONE;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
`else
                    state <= round_out;
                    rkey  <= next_rk;
                    if (last_round) begin
                        AES_MSG_ENC <= round_out;
                        AES_DONE    <= 1'b1;
                        fsm         <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
`endif
                end
                DONE: begin
                    if (!AES_START) begin
                        AES_DONE <= 1'b0;
                        fsm      <= WAIT;
                    end
                end
                default: fsm <= WAIT;
            endcase
        end
    end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 SHALL have parameter: NR, 10, round count; only 10 (AES-128) supported.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: AES_START  input  1  level request; sampled only in WAIT.
REQ-005 SHALL have port: AES_KEY  input  128  cipher key.
REQ-006 SHALL have port: AES_MSG_DEC  input  128  plaintext.
REQ-007 SHALL have port: AES_MSG_ENC  output  128  ciphertext, registered.
REQ-008 SHALL have port: AES_DONE  output  1  result valid, registered.

Function
REQ-009 SHALL use FIPS-197 byte order: byte 0 = bits [127:120], state filled column-major.
REQ-010 SHALL implement states WAIT, ROUND, DONE; WAIT->ROUND on an edge with AES_START=1.
REQ-011 SHALL, on the WAIT->ROUND edge, capture state = AES_MSG_DEC ^ AES_KEY and round key = AES_KEY, and set the round counter to 1.
REQ-012 SHALL ignore AES_KEY, AES_MSG_DEC and AES_START changes while in ROUND.
REQ-013 SHALL, per round, apply SubBytes, ShiftRows, MixColumns (skipped when counter = 10), AddRoundKey with the next round key.
REQ-014 SHALL derive each next round key on the fly (RotWord, SubWord, Rcon[counter]), with no stored schedule.
REQ-015 SHALL take ROUND->DONE on the edge completing round 10, loading AES_MSG_ENC and asserting AES_DONE on that edge.
REQ-016 SHALL, with one round per cycle, assert AES_DONE 10 cycles after the START-sampling edge.
REQ-017 SHALL hold DONE with AES_DONE=1 while AES_START=1, and go DONE->WAIT on the first edge with AES_START=0.
REQ-018 SHALL pulse AES_DONE for exactly one cycle if AES_START is already low on arrival in DONE.
REQ-019 SHALL hold AES_MSG_ENC unchanged from DONE until the next completion, including through WAIT and ROUND.
REQ-020 SHALL perform GF(2^8) arithmetic mod x^8+x^4+x^3+x+1, with all byte operations 8-bit and no carries kept.

Reset
REQ-021 SHALL, on RESET=1 at any time including mid-ROUND, force WAIT, AES_DONE=0, AES_MSG_ENC=0, and clear state, key and counter asynchronously.
REQ-022 SHALL not begin a new operation until the first edge after RESET is released with AES_START=1.

Configuration
REQ-023 SHALL support macro AES_ENC_SPLIT_ROUND_EN.
- Defined: each round takes two cycles (sub-state SUB_SHIFT, then MIX_ADD) sharing one 16-S-box bank, so AES_DONE asserts 20 cycles after the START edge.
- Undefined: one round per cycle, as in REQ-016.
REQ-024 SHALL produce identical AES_MSG_ENC and handshake behaviour with or without the macro, apart from latency.

Structure
REQ-025 SHALL place in package aes_enc_pkg:
- state enum
- NR constant
- Rcon table
- xtime/GF-multiply functions
- ShiftRows/MixColumns functions
REQ-026 SHALL use one sub-module, aes_sbox (combinational 8-bit S-box lookup), instantiated 20 times (16 state plus 4 key bytes).

Verification
REQ-027 SHALL cover: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, START held high -> AES_MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE high 10 cycles after the start edge and held.
REQ-028 SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; lower START -> AES_DONE=0 the next cycle and WAIT entered.
REQ-029 SHALL cover: START pulsed for one cycle, inputs changed at cycle 3 -> result matches the originally captured inputs and AES_DONE is a single-cycle pulse.
REQ-030 SHALL cover: RESET asserted at round 5, released, then a new START with the first vector -> outputs 0 during reset, then the correct ciphertext at the normal latency.
REQ-031 SHALL cover: two back-to-back operations with different keys -> AES_MSG_ENC holds the first result until the second completes.
REQ-032 SHALL cover: the REQ-027 vector with AES_ENC_SPLIT_ROUND_EN defined -> same ciphertext, AES_DONE at cycle 20.
